// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, counter width, 50 MHz timing defaults and
// HD44780 command codes for the LCD1602 bus writer.
package lcd_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

    localparam int CW = 17;

    localparam int DEF_T_AS   = 2;
    localparam int DEF_T_PW   = 12;
    localparam int DEF_T_H    = 2;
    localparam int DEF_T_EXEC = 2000;
    localparam int DEF_T_LONG = 76000;

    localparam logic [7:0] CLEAR = 8'h01;
    localparam logic [7:0] HOME  = 8'h02;

    // Codes 0x01-0x03 (clear / return home) need the long execution wait.
    function automatic logic is_long(input logic rs, input logic [7:0] d);
        return !rs && (d & ~(CLEAR | HOME)) == 8'd0 && d != 8'd0;
    endfunction

endpackage

// File: rtl/lcd_delay.sv
// lcd_delay: loadable down-counter; a phase loaded with N raises done on its
// N-th (last) cycle so the FSM changes phase exactly N clocks after loading.
module lcd_delay
    import lcd_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic          done
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - CW'(1);

    assign done = cnt == CW'(1);

endmodule

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: drives the HD44780 parallel bus with setup, enable-width and
// hold timing, then waits out the controller execution time per byte.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int BUS4   = 0,
    parameter int T_AS   = DEF_T_AS,
    parameter int T_PW   = DEF_T_PW,
    parameter int T_H    = DEF_T_H,
    parameter int T_EXEC = DEF_T_EXEC,
    parameter int T_LONG = DEF_T_LONG
)(
    input  logic       C,
    input  logic       R,
    input  logic       STB,
    input  logic       RS_IN,
    input  logic [7:0] D_IN,
    output logic       RDY,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_D
);

    state_t        state, state_n;
    logic          rdy_n, e_n, rs_n, long_q, long_n, hi, hi_n;
    logic [7:0]    d_n, byte_q, byte_n;
    logic          load, done;
    logic [CW-1:0] value;

    lcd_delay u_delay (.clk(C), .rst(R), .load(load), .value(value), .done(done));

    assign LCD_RW = 1'b0;

    always_ff @(posedge C or posedge R)
        if (R) begin
            state  <= IDLE;
            RDY    <= 1'b1;
            LCD_E  <= 1'b0;
            LCD_RS <= 1'b0;
            LCD_D  <= 8'd0;
            byte_q <= 8'd0;
            long_q <= 1'b0;
            hi     <= 1'b0;
        end else begin
            state  <= state_n;
            RDY    <= rdy_n;
            LCD_E  <= e_n;
            LCD_RS <= rs_n;
            LCD_D  <= d_n;
            byte_q <= byte_n;
            long_q <= long_n;
            hi     <= hi_n;
        end

    always_comb begin
        state_n = state;
        rdy_n   = RDY;
        e_n     = LCD_E;
        rs_n    = LCD_RS;
        d_n     = LCD_D;
        byte_n  = byte_q;
        long_n  = long_q;
        hi_n    = hi;
        load    = 1'b0;
        value   = '0;
        case (state)
            IDLE: if (STB && RDY) begin
                rs_n    = RS_IN;
                byte_n  = D_IN;
                d_n     = BUS4 != 0 ? {D_IN[7:4], 4'h0} : D_IN;
                rdy_n   = 1'b0;
                long_n  = is_long(RS_IN, D_IN);
                hi_n    = BUS4 != 0;
                load    = 1'b1;
                value   = CW'(T_AS);
                state_n = SETUP;
            end
            SETUP: if (done) begin
                e_n     = 1'b1;
                load    = 1'b1;
                value   = CW'(T_PW);
                state_n = PULSE;
            end
            PULSE: if (done) begin
                e_n     = 1'b0;
                load    = 1'b1;
                value   = CW'(T_H);
                state_n = HOLD;
            end
            HOLD: if (done) begin
                load    = 1'b1;
                // In 4-bit mode the high nibble goes first; the low nibble gets its own strobe.
                if (hi) begin
                    d_n     = {byte_q[3:0], 4'h0};
                    hi_n    = 1'b0;
                    value   = CW'(T_AS);
                    state_n = SETUP;
                end else begin
                    value   = long_q ? CW'(T_LONG) : CW'(T_EXEC);
                    state_n = WAIT;
                end
            end
            WAIT: if (done) begin
                rdy_n   = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                rdy_n   = 1'b1;
                e_n     = 1'b0;
                rs_n    = 1'b0;
                d_n     = 8'd0;
                byte_n  = 8'd0;
                long_n  = 1'b0;
                hi_n    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb_lcd_bus_writer: directed checks of 8-bit and 4-bit bus timing, long/short
// waits, ignored strobes, back-to-back acceptance and asynchronous reset.
module tb_lcd_bus_writer;

    logic       C = 1'b0, R = 1'b1;
    logic       stb8 = 1'b0, rs8 = 1'b0, stb4 = 1'b0, rs4 = 1'b0;
    logic [7:0] d8 = 8'd0, d4 = 8'd0;
    logic       rdy8o, rs8o, rw8o, e8, rdy4o, rs4o, rw4o, e4;
    logic [7:0] d8o, d4o;
    int         checks = 0, errors = 0;

    always #5 C = ~C;

    lcd_bus_writer #(.BUS4(0), .T_LONG(7600)) dut8 (
        .C(C), .R(R), .STB(stb8), .RS_IN(rs8), .D_IN(d8), .RDY(rdy8o),
        .LCD_RS(rs8o), .LCD_RW(rw8o), .LCD_E(e8), .LCD_D(d8o));

    lcd_bus_writer #(.BUS4(1), .T_EXEC(50), .T_LONG(300)) dut4 (
        .C(C), .R(R), .STB(stb4), .RS_IN(rs4), .D_IN(d4), .RDY(rdy4o),
        .LCD_RS(rs4o), .LCD_RW(rw4o), .LCD_E(e4), .LCD_D(d4o));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps edges after acceptance, recording strobe edges, bus changes and RDY return.
    task automatic observe(input bit four, input int budget, input int inj,
                           output int rise1, output int fall1, output int rise2,
                           output int rdy_at, output int nchg,
                           output logic [7:0] dr1, output logic [7:0] dr2, output logic [7:0] lo);
        logic       pe, e, r;
        logic [8:0] pb, cb;
        rise1 = -1; fall1 = -1; rise2 = -1; rdy_at = -1; nchg = 0;
        dr1 = 8'd0; dr2 = 8'd0; lo = 8'd0;
        pe = four ? e4 : e8;
        pb = four ? {rs4o, d4o} : {rs8o, d8o};
        for (int n = 1; n <= budget; n++) begin
            @(posedge C); #1;
            if (n == inj) begin stb8 = 1'b1; rs8 = 1'b0; d8 = 8'hFF; end
            if (n == inj + 1) stb8 = 1'b0;
            e  = four ? e4 : e8;
            r  = four ? rdy4o : rdy8o;
            cb = four ? {rs4o, d4o} : {rs8o, d8o};
            lo = lo | (cb[7:0] & 8'h0F);
            if (cb != pb) nchg++;
            if (e && !pe) begin
                if (rise1 < 0) begin rise1 = n; dr1 = cb[7:0]; end
                else begin rise2 = n; dr2 = cb[7:0]; end
            end
            if (!e && pe && fall1 < 0) fall1 = n;
            pe = e;
            pb = cb;
            if (r) begin rdy_at = n; break; end
        end
    endtask

    task automatic start8(input logic rs, input logic [7:0] d);
        @(negedge C); rs8 = rs; d8 = d; stb8 = 1'b1;
        @(posedge C); #1; stb8 = 1'b0;
    endtask

    task automatic xfer8(input string tag, input logic rs, input logic [7:0] d, input int exp_rdy, input int inj);
        int r1, f1, r2, ra, nc;
        logic [7:0] a, b, l;
        start8(rs, d);
        chk({tag, "_d_at_k"}, d8o, d);
        chk({tag, "_rs_at_k"}, rs8o, rs);
        chk({tag, "_rdy_low"}, rdy8o, 1'b0);
        observe(1'b0, exp_rdy + 50, inj, r1, f1, r2, ra, nc, a, b, l);
        chk({tag, "_e_rise"}, r1, 2);
        chk({tag, "_e_fall"}, f1, 14);
        chk({tag, "_one_pulse"}, r2, -1);
        chk({tag, "_rdy_at"}, ra, exp_rdy);
        chk({tag, "_bus_stable"}, nc, 0);
    endtask

    initial begin
        int r1, f1, r2, ra, nc, n, hi_cnt;
        logic [7:0] a, b, l;
        logic [7:0] seq [3];
        seq = '{8'h31, 8'h32, 8'h33};

        repeat (3) @(posedge C);
        #1;
        chk("rst_rdy", rdy8o, 1'b1);
        chk("rst_e", e8, 1'b0);
        @(negedge C) R = 1'b0;
        @(posedge C); #1;
        chk("rel_rdy8", rdy8o, 1'b1);
        chk("rel_e8", e8, 1'b0);
        chk("rel_rs8", rs8o, 1'b0);
        chk("rel_d8", d8o, 8'h00);
        chk("rel_rw8", rw8o, 1'b0);
        chk("rel_rdy4", rdy4o, 1'b1);
        chk("rel_d4", d4o, 8'h00);

        xfer8("data41", 1'b1, 8'h41, 2016, -1);
        xfer8("clear", 1'b0, 8'h01, 7616, -1);
        xfer8("fnset38", 1'b0, 8'h38, 2016, -1);
        xfer8("cmd03", 1'b0, 8'h03, 7616, -1);
        xfer8("cmd04", 1'b0, 8'h04, 2016, -1);
        xfer8("data01", 1'b1, 8'h01, 2016, -1);

        xfer8("ignore", 1'b1, 8'h41, 2016, 100);
        repeat (3) @(posedge C);
        #1;
        chk("ignore_still_idle", rdy8o, 1'b1);
        chk("ignore_bus_kept", d8o, 8'h41);
        chk("ignore_rs_kept", rs8o, 1'b1);

        @(negedge C); rs8 = 1'b1; d8 = seq[0]; stb8 = 1'b1;
        @(posedge C); #1;
        chk("b2b_first_d", d8o, seq[0]);
        chk("b2b_first_rdy", rdy8o, 1'b0);
        d8 = seq[1];
        for (int i = 1; i < 3; i++) begin
            n = 0;
            hi_cnt = 0;
            while (n < 2100) begin
                @(posedge C); #1;
                n++;
                if (rdy8o) hi_cnt++;
                else if (hi_cnt > 0) break;
            end
            chk($sformatf("b2b_interval_%0d", i), n, 2017);
            chk($sformatf("b2b_rdy_width_%0d", i), hi_cnt, 1);
            chk($sformatf("b2b_d_%0d", i), d8o, seq[i]);
            if (i < 2) d8 = seq[i + 1];
            else stb8 = 1'b0;
        end
        observe(1'b0, 2100, -1, r1, f1, r2, ra, nc, a, b, l);
        chk("b2b_last_rdy", ra, 2016);

        start8(1'b1, 8'h77);
        repeat (5) @(posedge C);
        #1;
        chk("arst_in_pulse", e8, 1'b1);
        #2 R = 1'b1;
        #1;
        chk("arst_e_async", e8, 1'b0);
        chk("arst_rdy", rdy8o, 1'b1);
        chk("arst_d", d8o, 8'h00);
        chk("arst_rs", rs8o, 1'b0);
        @(negedge C) R = 1'b0;
        xfer8("post_rst", 1'b1, 8'h5A, 2016, -1);

        @(negedge C); rs4 = 1'b1; d4 = 8'hA5; stb4 = 1'b1;
        @(posedge C); #1; stb4 = 1'b0;
        chk("b4_d_at_k", d4o, 8'hA0);
        chk("b4_rs_at_k", rs4o, 1'b1);
        observe(1'b1, 200, -1, r1, f1, r2, ra, nc, a, b, l);
        chk("b4_rise1", r1, 2);
        chk("b4_fall1", f1, 14);
        chk("b4_rise2", r2, 18);
        chk("b4_hi_nibble", a, 8'hA0);
        chk("b4_lo_nibble", b, 8'h50);
        chk("b4_low_bits_zero", l, 8'h00);
        chk("b4_bus_changes", nc, 1);
        chk("b4_rdy_at", ra, 82);

        @(negedge C); rs4 = 1'b0; d4 = 8'h02; stb4 = 1'b1;
        @(posedge C); #1; stb4 = 1'b0;
        chk("b4_home_d_at_k", d4o, 8'h00);
        observe(1'b1, 400, -1, r1, f1, r2, ra, nc, a, b, l);
        chk("b4_home_lo", b, 8'h20);
        chk("b4_home_rdy_at", ra, 332);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
